// File: rtl/rst_seq_ctrl.sv
// Staged reset sequencer: holds all domain resets, then releases them one at a time
// in index order, and re-runs the sequence on an accepted software request.
module rst_seq_ctrl #(
    parameter int unsigned NUM_STAGES  = 3,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned GAP_CYCLES  = 4,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  sw_rst_req,
    output logic                  sw_rst_ack,
    output logic [NUM_STAGES-1:0] stage_rstn,
    output logic                  busy,
    output logic                  all_released
);

    localparam int unsigned IDX_W = $clog2(NUM_STAGES + 1);

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_nxt;
    logic [IDX_W-1:0]        idx;
    logic [IDX_W-1:0]        idx_nxt;
    logic [NUM_STAGES-1:0]   stage_nxt;
    logic                    ack_nxt;
    logic                    busy_nxt;
    logic                    all_nxt;

    logic accept_c;
    logic hold_hit_c;
    logic gap_hit_c;
    logic last_idx_c;

    // A held request is re-accepted only every other cycle because the ack is still high.
    assign accept_c   = sw_rst_req && !sw_rst_ack;
    assign hold_hit_c = (cnt == CNT_W'(HOLD_CYCLES - 1));
    assign gap_hit_c  = (cnt == CNT_W'(GAP_CYCLES - 1));
    assign last_idx_c = (idx == IDX_W'(NUM_STAGES - 1));

    // State and registered outputs; RSTN overrides everything, including a pending ack.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state        <= ST_ASSERT;
            cnt          <= '0;
            idx          <= '0;
            stage_rstn   <= '0;
            sw_rst_ack   <= 1'b0;
            busy         <= 1'b1;
            all_released <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            idx          <= idx_nxt;
            stage_rstn   <= stage_nxt;
            sw_rst_ack   <= ack_nxt;
            busy         <= busy_nxt;
            all_released <= all_nxt;
        end
    end

    // Next-state, counter and stage index.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        if (accept_c) begin
            state_nxt = ST_ASSERT;
            cnt_nxt   = '0;
            idx_nxt   = '0;
        end else begin
            case (state)
                ST_ASSERT: begin
                    if (hold_hit_c) begin
                        cnt_nxt   = '0;
                        idx_nxt   = IDX_W'(1);
                        state_nxt = (NUM_STAGES == 1) ? ST_DONE : ST_RELEASE;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (gap_hit_c) begin
                        cnt_nxt = '0;
                        idx_nxt = idx + IDX_W'(1);
                        if (last_idx_c) begin
                            state_nxt = ST_DONE;
                        end
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    state_nxt = ST_DONE;
                end
                default: begin
                    state_nxt = ST_ASSERT;
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                end
            endcase
        end
    end

    // Next values of the registered outputs.
    always_comb begin
        stage_nxt = stage_rstn;
        ack_nxt   = 1'b0;
        busy_nxt  = busy;
        all_nxt   = all_released;
        if (accept_c) begin
            stage_nxt = '0;
            ack_nxt   = 1'b1;
            busy_nxt  = 1'b1;
            all_nxt   = 1'b0;
        end else begin
            case (state)
                ST_ASSERT: begin
                    if (hold_hit_c) begin
                        stage_nxt[0] = 1'b1;
                        if (NUM_STAGES == 1) begin
                            busy_nxt = 1'b0;
                            all_nxt  = 1'b1;
                        end
                    end
                end
                ST_RELEASE: begin
                    if (gap_hit_c) begin
                        for (int unsigned i = 0; i < NUM_STAGES; i++) begin
                            if (IDX_W'(i) == idx) begin
                                stage_nxt[i] = 1'b1;
                            end
                        end
                        if (last_idx_c) begin
                            busy_nxt = 1'b0;
                            all_nxt  = 1'b1;
                        end
                    end
                end
                default: begin
                    stage_nxt = stage_rstn;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Scoreboard bench for rst_seq_ctrl: expected output events (cycle + value) are queued by
// the stimulus and checked by monitors whenever a DUT's outputs change or ack is high.
module tb_rst_seq_ctrl;

    typedef struct {
        int         cyc;
        logic [5:0] val;
    } ev_t;

    logic       clk  = 1'b0;
    logic       rstn = 1'b0;
    logic       req  = 1'b0;
    logic       req1 = 1'b0;

    logic       ack;
    logic [2:0] stg;
    logic       bsy;
    logic       alr;
    logic       ack1;
    logic [0:0] stg1;
    logic       bsy1;
    logic       alr1;

    int  cyc    = 0;
    int  checks = 0;
    int  errors = 0;
    ev_t q0[$];
    ev_t q1[$];

    rst_seq_ctrl #(.NUM_STAGES(3), .HOLD_CYCLES(16), .GAP_CYCLES(4), .CNT_W(8)) dut (
        .CLK(clk), .RSTN(rstn), .sw_rst_req(req), .sw_rst_ack(ack),
        .stage_rstn(stg), .busy(bsy), .all_released(alr)
    );

    rst_seq_ctrl #(.NUM_STAGES(1), .HOLD_CYCLES(1), .GAP_CYCLES(4), .CNT_W(8)) dut1 (
        .CLK(clk), .RSTN(rstn), .sw_rst_req(req1), .sw_rst_ack(ack1),
        .stage_rstn(stg1), .busy(bsy1), .all_released(alr1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected value layout: {ack, stage[2:0], busy, all_released}
    function automatic void push0(int c, logic a, logic [2:0] s, logic b, logic r);
        ev_t e;
        e.cyc = c;
        e.val = {a, s, b, r};
        q0.push_back(e);
    endfunction

    function automatic void push1(int c, logic a, logic s, logic b, logic r);
        ev_t e;
        e.cyc = c;
        e.val = {a, 2'b00, s, b, r};
        q1.push_back(e);
    endfunction

    logic [5:0] prev0 = 'x;
    logic [5:0] prev1 = 'x;

    always @(negedge clk) begin
        logic [5:0] snap;
        ev_t        e;
        snap = {ack, stg, bsy, alr};
        if (snap !== prev0 || ack === 1'b1) begin
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL main_unexpected cyc=%0d got=%b", cyc, snap);
            end else begin
                e = q0.pop_front();
                if (e.cyc != cyc || e.val !== snap) begin
                    errors++;
                    $display("FAIL main_event got cyc=%0d val=%b expected cyc=%0d val=%b",
                             cyc, snap, e.cyc, e.val);
                end
            end
        end
        prev0 = snap;
    end

    always @(negedge clk) begin
        logic [5:0] snap;
        ev_t        e;
        snap = {ack1, 2'b00, stg1, bsy1, alr1};
        if (snap !== prev1 || ack1 === 1'b1) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL corner_unexpected cyc=%0d got=%b", cyc, snap);
            end else begin
                e = q1.pop_front();
                if (e.cyc != cyc || e.val !== snap) begin
                    errors++;
                    $display("FAIL corner_event got cyc=%0d val=%b expected cyc=%0d val=%b",
                             cyc, snap, e.cyc, e.val);
                end
            end
        end
        prev1 = snap;
    end

    task automatic wait_to(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // Power-on: reset held for edges 1..5, first edge with RSTN high is 6.
        push0(1, 1'b0, 3'b000, 1'b1, 1'b0);
        push1(1, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_to(5);
        rstn = 1'b1;
        push0(21, 1'b0, 3'b001, 1'b1, 1'b0);
        push0(25, 1'b0, 3'b011, 1'b1, 1'b0);
        push0(29, 1'b0, 3'b111, 1'b0, 1'b1);
        push1(6, 1'b0, 1'b1, 1'b0, 1'b1);

        // Single-cycle request in DONE, accepted at 36.
        push0(36, 1'b1, 3'b000, 1'b1, 1'b0);
        push0(37, 1'b0, 3'b000, 1'b1, 1'b0);
        push0(52, 1'b0, 3'b001, 1'b1, 1'b0);
        wait_to(35);
        req = 1'b1;
        wait_to(36);
        req = 1'b0;

        // Request mid-RELEASE (stage 001), accepted at 54; restart releases at 70/74/78.
        push0(54, 1'b1, 3'b000, 1'b1, 1'b0);
        push0(55, 1'b0, 3'b000, 1'b1, 1'b0);
        push0(70, 1'b0, 3'b001, 1'b1, 1'b0);
        push0(74, 1'b0, 3'b011, 1'b1, 1'b0);
        push0(78, 1'b0, 3'b111, 1'b0, 1'b1);
        wait_to(53);
        req = 1'b1;
        wait_to(54);
        req = 1'b0;

        // Request held four edges in DONE: ack 1,0,1,0; final restart at 88.
        push0(86, 1'b1, 3'b000, 1'b1, 1'b0);
        push0(87, 1'b0, 3'b000, 1'b1, 1'b0);
        push0(88, 1'b1, 3'b000, 1'b1, 1'b0);
        push0(89, 1'b0, 3'b000, 1'b1, 1'b0);
        push0(104, 1'b0, 3'b001, 1'b1, 1'b0);
        push0(108, 1'b0, 3'b011, 1'b1, 1'b0);
        wait_to(85);
        req = 1'b1;
        wait_to(89);
        req = 1'b0;

        // RSTN drop with a simultaneous request while at 011; reset wins, no ack.
        push0(110, 1'b0, 3'b000, 1'b1, 1'b0);
        push1(110, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_to(109);
        rstn = 1'b0;
        req  = 1'b1;
        wait_to(111);
        rstn = 1'b1;
        req  = 1'b0;
        push0(127, 1'b0, 3'b001, 1'b1, 1'b0);
        push0(131, 1'b0, 3'b011, 1'b1, 1'b0);
        push0(135, 1'b0, 3'b111, 1'b0, 1'b1);
        push1(112, 1'b0, 1'b1, 1'b0, 1'b1);

        wait_to(145);
        @(negedge clk);
        checks++;
        if (q0.size() != 0) begin
            errors++;
            $display("FAIL main_missing_events got pending=%0d expected pending=0", q0.size());
        end
        checks++;
        if (q1.size() != 0) begin
            errors++;
            $display("FAIL corner_missing_events got pending=%0d expected pending=0", q1.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
